// File: rtl/debug_run_ctrl.sv
// rtl/debug_run_ctrl.sv - button-driven RUN/HALTED/STEP run control for the core HALT input
//
// Purpose: synchronises and debounces three push-buttons, turns debounced
// rising edges into one-cycle press pulses, and runs the RUN/HALTED/STEP
// state machine that drives the core HALT input. Also counts clocks in which
// the core was allowed to run.
//
// Optional feature macro: DEBUG_RUN_CTRL_BREAKPOINT_EN adds a PC breakpoint
// (pc, bp_addr, bp_en) that forces HALTED from RUN or STEP.
//
// Ports:
//   CLK100MHZ   in   1   system clock, rising edge
//   RST         in   1   synchronous active-high reset
//   btn_halt    in   1   raw button, press requests halt
//   btn_run     in   1   raw button, press requests resume
//   btn_step    in   1   raw button, press requests a single step
//   pc          in  32   core instruction address (breakpoint build only)
//   bp_addr     in  32   breakpoint address (breakpoint build only)
//   bp_en       in   1   breakpoint enable (breakpoint build only)
//   halt        out  1   1 = core frozen
//   state       out  2   00 RUN, 01 HALTED, 10 STEP
//   step_done   out  1   one-cycle pulse when a step completes
//   run_cycles  out 32   saturating count of clocks with halt == 0
module debug_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned STEP_CYCLES     = 1,
    parameter bit          START_HALTED    = 1'b0
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic        btn_halt,
    input  logic        btn_run,
    input  logic        btn_step,
`ifdef DEBUG_RUN_CTRL_BREAKPOINT_EN
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_en,
`endif
    output logic        halt,
    output logic [1:0]  state,
    output logic        step_done,
    output logic [31:0] run_cycles
);

    localparam int B_HALT = 0;
    localparam int B_RUN  = 1;
    localparam int B_STEP = 2;

    // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int DBW = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

    localparam int SCW = ($clog2(STEP_CYCLES + 1) > 1) ? $clog2(STEP_CYCLES + 1) : 1;
    localparam logic [SCW-1:0] STEP_LOAD = SCW'(STEP_CYCLES);
    localparam logic [SCW-1:0] SC_ONE    = SCW'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_STEP   = 2'b10
    } state_e;

    logic [2:0]     btn_raw;
    logic [2:0]     sync1_q;
    logic [2:0]     sync2_q;
    logic [2:0]     db_q;
    logic [2:0]     db_dly_q;
    logic [2:0]     press_q;
    logic [DBW-1:0] db_cnt_q [3];

    state_e         state_q;
    logic           halt_q;
    logic           step_done_q;
    logic [SCW-1:0] step_cnt_q;
    logic [31:0]    run_cycles_q;
    logic [31:0]    run_cycles_d;
    logic           bp_hit;

    assign btn_raw = {btn_step, btn_run, btn_halt};

`ifdef DEBUG_RUN_CTRL_BREAKPOINT_EN
    assign bp_hit = bp_en && (pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // Two-flop synchronisers, debounce counters and press-pulse generation.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
            for (int b = 0; b < 3; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            // Only debounced rising edges produce a press; releases are silent.
            press_q  <= db_q & ~db_dly_q;
            for (int b = 0; b < 3; b++) begin
                if (sync2_q[b] == db_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_LAST) begin
                    db_q[b]     <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + DB_ONE;
                end
            end
        end
    end

    // Run/halt state machine; halt is registered alongside the state.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q     <= START_HALTED ? ST_HALTED : ST_RUN;
            halt_q      <= START_HALTED;
            step_done_q <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            step_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (bp_hit || press_q[B_HALT]) begin
                        state_q <= ST_HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    // A breakpoint is ignored here so the user can leave it.
                    if (!press_q[B_HALT]) begin
                        if (press_q[B_STEP]) begin
                            state_q    <= ST_STEP;
                            halt_q     <= 1'b0;
                            step_cnt_q <= STEP_LOAD;
                        end else if (press_q[B_RUN]) begin
                            state_q <= ST_RUN;
                            halt_q  <= 1'b0;
                        end
                    end
                end
                ST_STEP: begin
                    if (bp_hit || press_q[B_HALT]) begin
                        // Aborted step: no completion pulse.
                        state_q <= ST_HALTED;
                        halt_q  <= 1'b1;
                    end else if (step_cnt_q == SC_ONE) begin
                        state_q     <= ST_HALTED;
                        halt_q      <= 1'b1;
                        step_done_q <= 1'b1;
                    end else begin
                        step_cnt_q <= step_cnt_q - SC_ONE;
                    end
                end
                default: begin
                    // Unused encoding 2'b11: park safely in HALTED.
                    state_q <= ST_HALTED;
                    halt_q  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (!halt_q && (run_cycles_q != 32'hFFFF_FFFF)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign halt       = halt_q;
    assign state      = state_q;
    assign step_done  = step_done_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// tb/tb_debug_run_ctrl.sv - self-checking bench for debug_run_ctrl
module tb_debug_run_ctrl;

    localparam int D = 4;
    localparam int S = 3;

    localparam int M_RUN    = 0;
    localparam int M_HALTED = 1;
    localparam int M_STEP   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        b_halt = 1'b0;
    logic        b_run = 1'b0;
    logic        b_step = 1'b0;
    logic        halt;
    logic [1:0]  state;
    logic        step_done;
    logic [31:0] run_cycles;
`ifdef DEBUG_RUN_CTRL_BREAKPOINT_EN
    logic [31:0] pc = 32'd0;
    logic [31:0] bp_addr = 32'd0;
    logic        bp_en = 1'b0;
`endif

    always #5 clk = ~clk;

    debug_run_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .STEP_CYCLES(S),
        .START_HALTED(1'b0)
    ) dut (
        .CLK100MHZ(clk),
        .RST(rst),
        .btn_halt(b_halt),
        .btn_run(b_run),
        .btn_step(b_step),
`ifdef DEBUG_RUN_CTRL_BREAKPOINT_EN
        .pc(pc),
        .bp_addr(bp_addr),
        .bp_en(bp_en),
`endif
        .halt(halt),
        .state(state),
        .step_done(step_done),
        .run_cycles(run_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode, remaining zero-halt clocks of a step, and a
    // history of raw button samples from which debounced levels are derived.
    int          m_mode;
    logic        m_halt;
    logic        m_done;
    logic [31:0] m_run;
    int          m_left;
    logic [2:0]  m_db;
    logic [2:0]  m_db_d;
    logic [2:0]  m_press;
    logic [2:0]  hist [$];

    task automatic model_reset();
        m_mode  = M_RUN;
        m_halt  = 1'b0;
        m_done  = 1'b0;
        m_run   = 32'd0;
        m_left  = 0;
        m_db    = 3'b000;
        m_db_d  = 3'b000;
        m_press = 3'b000;
        hist.delete();
        hist.push_back(3'b000);
        hist.push_back(3'b000);
    endtask

    task automatic model_step();
        logic [2:0] p;
        logic [2:0] db_new;
        logic [2:0] pr_new;
        logic       bp;
        logic       stable;
        int         len;
        if (rst) begin
            model_reset();
        end else begin
            p  = m_press;
            bp = 1'b0;
`ifdef DEBUG_RUN_CTRL_BREAKPOINT_EN
            bp = bp_en && (pc == bp_addr);
`endif
            if (!m_halt && m_run != 32'hFFFF_FFFF) m_run = m_run + 32'd1;
            m_done = 1'b0;
            if (m_mode == M_RUN) begin
                if (bp || p[0]) m_mode = M_HALTED;
            end else if (m_mode == M_HALTED) begin
                if (p[0]) m_mode = M_HALTED;
                else if (p[2]) begin m_mode = M_STEP; m_left = S; end
                else if (p[1]) m_mode = M_RUN;
            end else begin
                if (bp || p[0]) m_mode = M_HALTED;
                else if (m_left == 1) begin m_mode = M_HALTED; m_done = 1'b1; end
                else m_left = m_left - 1;
            end
            m_halt = (m_mode == M_HALTED);
            pr_new = m_db & ~m_db_d;
            // Level flips once the synchronised input (raw delayed two edges)
            // has disagreed with it for D consecutive edges.
            hist.push_back({b_step, b_run, b_halt});
            len    = hist.size();
            db_new = m_db;
            if (len - 2 - D >= 0) begin
                for (int b = 0; b < 3; b++) begin
                    stable = 1'b1;
                    for (int i = len - 2 - D; i <= len - 3; i++) begin
                        if (hist[i][b] == m_db[b]) stable = 1'b0;
                    end
                    if (stable) db_new[b] = ~m_db[b];
                end
            end
            while (hist.size() > D + 4) void'(hist.pop_front());
            m_db_d  = m_db;
            m_db    = db_new;
            m_press = pr_new;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("model_state", {30'd0, state}, m_mode);
        chk("model_halt", {31'd0, halt}, {31'd0, m_halt});
        chk("model_step_done", {31'd0, step_done}, {31'd0, m_done});
        chk("model_run_cycles", run_cycles, m_run);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    int          zeros;
    int          dones;
    int          found;
    int          seg_len;
    logic [31:0] r0;

    initial begin
        model_reset();

        // Reset state and free-running counter
        rst = 1'b1;
        tick();
        tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_step_done", {31'd0, step_done}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("run_count_3", run_cycles, 32'd3);

        // Halt press latency: held from before edge 1, halt at edge 4+D
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        b_halt = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("halt_early", {31'd0, halt}, 32'd0);
        end
        tick();
        chk("halt_edge8", {31'd0, halt}, 32'd1);
        chk("state_edge8", {30'd0, state}, 32'd1);
        chk("run_at_halt", run_cycles, 32'd8);
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("run_frozen", run_cycles, 32'd8);
        end
        b_halt = 1'b0;
        repeat (10) tick();

        // Glitches shorter than D are ignored
        for (int c = 0; c < 40; c++) begin
            b_halt = ((c / 3) % 2 == 0);
            b_run  = ((c / 3) % 2 == 1);
            tick();
            chk("glitch_halt", {31'd0, halt}, 32'd1);
            chk("glitch_state", {30'd0, state}, 32'd1);
        end
        b_halt = 1'b0;
        b_run  = 1'b0;
        repeat (10) tick();

        // Single step
        r0    = run_cycles;
        zeros = 0;
        dones = 0;
        b_step = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 6) b_step = 1'b0;
            tick();
            if (!halt) zeros++;
            if (step_done) begin
                dones++;
                chk("done_state", {30'd0, state}, 32'd1);
            end
        end
        chk("step_zero_clocks", zeros, S);
        chk("step_done_count", dones, 32'd1);
        chk("step_run_delta", run_cycles - r0, S);
        chk("step_end_state", {30'd0, state}, 32'd1);

        // Step and halt together: halt wins
        b_step = 1'b1;
        b_halt = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (c == 6) begin
                b_step = 1'b0;
                b_halt = 1'b0;
            end
            tick();
            chk("coinc_state", {30'd0, state}, 32'd1);
            chk("coinc_halt", {31'd0, halt}, 32'd1);
        end

        // Reset in the middle of a step
        found  = 0;
        b_step = 1'b1;
        for (int c = 0; c < 30 && found == 0; c++) begin
            if (c == 6) b_step = 1'b0;
            tick();
            if (state == 2'b10) found = 1;
        end
        b_step = 1'b0;
        chk("step_entered", found, 32'd1);
        rst = 1'b1;
        tick();
        chk("midstep_rst_state", {30'd0, state}, 32'd0);
        chk("midstep_rst_halt", {31'd0, halt}, 32'd0);
        chk("midstep_rst_run", run_cycles, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

`ifdef DEBUG_RUN_CTRL_BREAKPOINT_EN
        // Breakpoint halts from RUN, run press leaves it
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 32'h8;
        pc      = 32'h0;
        tick();
        chk("bp_pc0", {31'd0, halt}, 32'd0);
        pc = 32'h4;
        tick();
        chk("bp_pc4", {31'd0, halt}, 32'd0);
        pc = 32'h8;
        tick();
        chk("bp_hit_halt", {31'd0, halt}, 32'd1);
        chk("bp_hit_state", {30'd0, state}, 32'd1);
        found = 0;
        b_run = 1'b1;
        for (int c = 0; c < 30 && found == 0; c++) begin
            if (c == 6) b_run = 1'b0;
            tick();
            if (state == 2'b00) found = 1;
        end
        b_run = 1'b0;
        chk("bp_resume", found, 32'd1);
        pc = 32'hC;
        tick();
        chk("bp_resume_state", {30'd0, state}, 32'd0);
        bp_en = 1'b0;
`endif

        // Randomised levels checked cycle by cycle against the model
        for (int seg = 0; seg < 150; seg++) begin
            b_halt = ($urandom_range(0, 3) == 0);
            b_run  = ($urandom_range(0, 1) == 0);
            b_step = ($urandom_range(0, 1) == 0);
            rst    = ($urandom_range(0, 29) == 0);
`ifdef DEBUG_RUN_CTRL_BREAKPOINT_EN
            bp_en   = ($urandom_range(0, 1) == 0);
            bp_addr = 32'h8;
            pc      = 32'($urandom_range(0, 3)) * 32'd4;
`endif
            seg_len = $urandom_range(1, 10);
            for (int k = 0; k < seg_len; k++) begin
                tick();
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
